// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte strobes to byte-wide register bus bridge
module spi_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  READ_FILL      = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_n_i,
    input  logic [7:0]  spi_data_i,
    input  logic [15:0] spi_addr_i,
    input  logic        spi_data_wr_i,
    output logic        spi_wr_done_o,
    input  logic        spi_data_req_i,
    output logic [7:0]  spi_data_o,
    output logic        spi_data_rd_o,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    input  logic [7:0]  reg_rdata_i,
    input  logic        reg_ack_i,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BUS,
        S_WR_DONE,
        S_RD_BUS,
        S_RD_PRESENT,
        S_RD_DONE
    } state_t;

    logic wr_meta_q, wr_sync_q, wr_prev_q;
    logic rd_meta_q, rd_sync_q, rd_prev_q;
    logic cs_meta_q, cs_sync_q;
    logic wr_rise, rd_rise;

    state_t      state_q, state_d;
    logic [5:0]  offset_q, offset_d;
    logic [5:0]  base_off;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_rd_q, pend_rd_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        wr_done_q, wr_done_d;
    logic        data_rd_q, data_rd_d;
    logic        err_q, err_d;
    logic        timeout_hit;

    // Two-flop synchronizers for the SPI-domain strobes plus an edge register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_meta_q <= 1'b0;
            wr_sync_q <= 1'b0;
            wr_prev_q <= 1'b0;
            rd_meta_q <= 1'b0;
            rd_sync_q <= 1'b0;
            rd_prev_q <= 1'b0;
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
        end else begin
            wr_meta_q <= spi_data_wr_i;
            wr_sync_q <= wr_meta_q;
            wr_prev_q <= wr_sync_q;
            rd_meta_q <= spi_data_req_i;
            rd_sync_q <= rd_meta_q;
            rd_prev_q <= rd_sync_q;
            cs_meta_q <= cs_n_i;
            cs_sync_q <= cs_meta_q;
        end
    end

    assign wr_rise = wr_sync_q & ~wr_prev_q;
    assign rd_rise = rd_sync_q & ~rd_prev_q;

    // Next-state and registered-output computation for the access FSM
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        pend_rd_d   = pend_rd_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wr_done_d   = wr_done_q;
        data_rd_d   = data_rd_q;
        timeout_hit = 1'b0;
        base_off    = cs_sync_q ? 6'd0 : offset_q;

        // A read edge arriving while busy is served once the FSM is back in IDLE
        if (rd_rise && (state_q != S_IDLE)) begin
            pend_rd_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                offset_d = base_off;
                if (wr_rise) begin
                    state_d = S_WR_BUS;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = spi_data_i;
                    addr_d  = spi_addr_i + {10'd0, base_off};
                    cnt_d   = 16'd0;
                    if (rd_rise) begin
                        pend_rd_d = 1'b1;
                    end
                end else if (rd_rise || pend_rd_q) begin
                    state_d   = S_RD_BUS;
                    req_d     = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = spi_addr_i + {10'd0, base_off};
                    cnt_d     = 16'd0;
                    pend_rd_d = 1'b0;
                end
            end
            S_WR_BUS: begin
                if (reg_ack_i || (cnt_q == TO_LAST)) begin
                    timeout_hit = ~reg_ack_i;
                    req_d       = 1'b0;
                    wr_done_d   = 1'b1;
                    state_d     = S_WR_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WR_DONE: begin
                if (!wr_sync_q) begin
                    wr_done_d = 1'b0;
                    offset_d  = offset_q + 6'd1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_BUS: begin
                if (reg_ack_i) begin
                    rdata_d = reg_rdata_i;
                    req_d   = 1'b0;
                    state_d = S_RD_PRESENT;
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    rdata_d     = READ_FILL;
                    req_d       = 1'b0;
                    state_d     = S_RD_PRESENT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD_PRESENT: begin
                data_rd_d = 1'b1;
                state_d   = S_RD_DONE;
            end
            S_RD_DONE: begin
                if (!rd_sync_q) begin
                    data_rd_d = 1'b0;
                    offset_d  = offset_q + 6'd1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A fresh timeout outranks a clear arriving in the same cycle
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Access FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            offset_q  <= 6'd0;
            cnt_q     <= 16'd0;
            pend_rd_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            wr_done_q <= 1'b0;
            data_rd_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wr_done_q <= wr_done_d;
            data_rd_q <= data_rd_d;
            err_q     <= err_d;
        end
    end

    assign reg_req_o     = req_q;
    assign reg_we_o      = we_q;
    assign reg_addr_o    = addr_q;
    assign reg_wdata_o   = wdata_q;
    assign spi_data_o    = rdata_q;
    assign spi_wr_done_o = wr_done_q;
    assign spi_data_rd_o = data_rd_q;
    assign err_o         = err_q;

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Data-provider stage sitting directly downstream of `spi_periph`: it consumes the byte-level write/read strobes that `spi_periph` raises during a TPM SPI transaction and converts them into byte-wide accesses on the internal register bus. The bridge runs on the system clock. It synchronizes the SPI-domain strobes, tracks the byte offset within the current transaction, and completes the four-phase `data_wr`/`wr_done` and `data_req`/`data_rd` handshakes toward `spi_periph`. A bus-acknowledge timeout and a sticky error flag are included.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: clk_i cycles to wait for `reg_ack_i` before the access is abandoned (1..65535).
- `READ_FILL`, 8'hFF: byte returned to SPI on a timed-out read.

Ports (one clock `clk_i`; reset `rst_n_i` is asynchronous, active-low):
- `clk_i` input 1: system clock.
- `rst_n_i` input 1: asynchronous active-low reset.
- `cs_n_i` input 1: SPI chip select, raw (SPI pad domain).
- `spi_data_i` input 8: write byte from `spi_periph` `data_o`.
- `spi_addr_i` input 16: TPM address from `spi_periph` `addr_o`.
- `spi_data_wr_i` input 1: `spi_periph` `data_wr`; `spi_data_i` is valid while high.
- `spi_wr_done_o` output 1: to `spi_periph` `wr_done`.
- `spi_data_req_i` input 1: `spi_periph` `data_req`.
- `spi_data_o` output 8: to `spi_periph` `data_i`.
- `spi_data_rd_o` output 1: to `spi_periph` `data_rd`.
- `reg_req_o` output 1: bus request; held until ack or timeout.
- `reg_we_o` output 1: 1 = write, 0 = read.
- `reg_addr_o` output 16: byte address.
- `reg_wdata_o` output 8: write byte.
- `reg_rdata_i` input 8: read byte; valid with `reg_ack_i`.
- `reg_ack_i` input 1: single-cycle acknowledge.
- `err_o` output 1: sticky timeout flag.
- `err_clr_i` input 1: clears `err_o`.

## Operation
- **Synchronization.** `spi_data_wr_i`, `spi_data_req_i` and `cs_n_i` each pass through a 2-FF synchronizer; rising edges are detected on the synchronized versions.
- **Data-path sampling.** `spi_data_i` and `spi_addr_i` are sampled only on a synchronized rising edge. `spi_periph` holds them stable for the whole strobe-high period.
- **Byte offset.** 6-bit `offset`.
  - Cleared while synchronized `cs_n` is high and the FSM is in IDLE.
  - Incremented by 1 on completion of every write or read byte; wraps 63→0.
  - `reg_addr_o = spi_addr_i + offset`, modulo 2^16 (0xFFFF+1 → 0x0000).
- **FSM states.**
  - **IDLE.**
    - Synchronized `data_wr` rise → WR_BUS: latch byte, `reg_we_o=1`.
    - Synchronized `data_req` rise → RD_BUS: `reg_we_o=0`.
    - Both rising in the same cycle: the write is served first; the read edge is remembered and served right after WR_DONE.
  - **WR_BUS.** `reg_req_o=1` until `reg_ack_i` or timeout, then → WR_DONE.
  - **WR_DONE.** `spi_wr_done_o=1` until synchronized `data_wr` is low, then `spi_wr_done_o=0`, offset+1, → IDLE.
  - **RD_BUS.** `reg_req_o=1` until `reg_ack_i` (capture `reg_rdata_i` into `spi_data_o`) or timeout (load `READ_FILL`), then → RD_PRESENT.
  - **RD_PRESENT.** One cycle; `spi_data_o` is already stable. → RD_DONE.
  - **RD_DONE.** `spi_data_rd_o=1` until synchronized `data_req` is low, then `spi_data_rd_o=0`, offset+1, → IDLE.
- **Timeout.** 16-bit counter, reset on each bus request.
  - Reaching `TIMEOUT_CYCLES` drops `reg_req_o`, sets `err_o` and completes the SPI handshake normally; a write is discarded.
- **Error flag.** If `err_clr_i` and a new timeout occur in the same cycle, set wins.
- **cs_n deasserts mid-access.** The current access runs to completion; the offset is cleared on return to IDLE.

## Timing
- **Reset values.** All outputs 0 (`spi_data_o`=0x00, `reg_addr_o`=0x0000); FSM in IDLE; offset 0. Reset mid-access drops `reg_req_o` immediately.
- **Request latency.** `reg_req_o` rises 3 clk_i cycles after an SPI strobe rise (2 sync + 1 edge register).
- **Bus release.** `reg_req_o` falls the cycle after `reg_ack_i` is sampled high.
- **`reg_ack_i` handling.** Ignored when `reg_req_o` is low. Ack on the timeout cycle counts as ack: no error.
- **Write completion.** `spi_wr_done_o` rises 1 cycle after ack.
- **Read completion.** `spi_data_o` is updated on the ack cycle; `spi_data_rd_o` rises 2 cycles after ack (data setup ≥1 clk_i).
- **Zero-wait bus.** With ack in the first request cycle, SPI strobe rise → done/rd rise is ≤6 clk_i cycles.
- **Handshake release.** Done/rd fall ≤3 cycles after the SPI strobe falls.

## Test plan
- **4-byte write, zero-wait ack.** Write 32'h113C359A at 0x4C4C (bytes sent LSB first) → bus writes 9A@4C4C, 35@4C4D, 3C@4C4E, 11@4C4F; `spi_wr_done_o` completes each handshake; `err_o`=0.
- **4-byte read, 10-cycle ack delay.** Read at 0xF0F0; bus returns 35,57,00,FA → `spi_data_o` presents 35,57,00,FA, each stable ≥1 cycle before `spi_data_rd_o` rises.
- **Timeout.** `reg_ack_i` never asserted on a 1-byte read at 0xFF00 → `reg_req_o` held exactly `TIMEOUT_CYCLES` cycles; `spi_data_o`=FF; `err_o`=1 until `err_clr_i` pulse.
- **Wrap and reset.** 2-byte write at 0xFFFF → addresses FFFF then 0000; `cs_n_i` high between transactions → next transaction starts at offset 0.
- **Simultaneous strobes.** `data_wr` and `data_req` rise in the same cycle → write bus access precedes read; both handshakes complete.
- **Reset mid-access.** Assert `rst_n_i` during RD_BUS → all outputs 0 asynchronously; a following 1-byte write 0x3C at 0xC44C completes normally.
